// File: rtl/cr_osf_dbg_step_sched_pkg.sv
//==== cr_osfPKG / cr_osf_regsPKG : shared types for the OSF debug step scheduler ====
//==== rev 1.0                                                                      ====
`default_nettype none

package cr_osfPKG;
   localparam int OSF_STEP_CNT_W = 16;
   localparam int OSF_STEP_GAP   = 2;
   localparam int OSF_STEP_TMO_W = 12;

   typedef enum logic {
      STEP_TGT_DATA = 1'b0,
      STEP_TGT_PDT  = 1'b1
   } step_tgt_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } step_state_e;
endpackage

package cr_osf_regsPKG;
   typedef struct packed {
      logic                                 valid;
      cr_osfPKG::step_tgt_e                 target;
      logic [cr_osfPKG::OSF_STEP_CNT_W-1:0] count;
      logic                                 abort;
   } step_cmd_t;

   typedef struct packed {
      logic                                 busy;
      logic                                 done;
      logic                                 err;
      logic                                 aborted;
      logic [cr_osfPKG::OSF_STEP_CNT_W-1:0] remaining;
      logic [cr_osfPKG::OSF_STEP_CNT_W-1:0] issued;
   } step_sts_t;
endpackage

`default_nettype wire

// File: rtl/cr_osf_dbg_step_sched_pacer.sv
//==== cr_osf_step_pacer : inter-pulse gap counter and stall timeout counter ====
//==== rev 1.0                                                              ====
`default_nettype none

module cr_osf_step_pacer #(
   parameter int STEP_GAP = 2,
   parameter int TMO_W    = 12
) (
   input  logic clk,
   input  logic rst_n,
   input  logic gap_load,
   input  logic gap_en,
   input  logic stall_clr,
   input  logic stall_inc,
   output logic gap_done,
   output logic timeout
);
   localparam int               GAP_W      = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(STEP_GAP - 1);
   localparam logic [TMO_W-1:0] STALL_LAST = TMO_W'((2 ** TMO_W) - 2);

   logic [GAP_W-1:0] gap_cnt;
   logic [TMO_W-1:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gap_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (gap_load)
            gap_cnt <= GAP_LOAD;
         else if (gap_en && (gap_cnt != '0))
            gap_cnt <= gap_cnt - 1'b1;

         if (stall_clr)
            stall_cnt <= '0;
         else if (stall_inc)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // timeout asserts on the cycle whose increment would make the counter all-ones
   assign gap_done = gap_en && (gap_cnt == '0);
   assign timeout  = stall_inc && (stall_cnt == STALL_LAST);
endmodule

`default_nettype wire

// File: rtl/cr_osf_dbg_step_sched.sv
//==== cr_osf_dbg_step_sched : paced single-step read scheduler for OSF debug FIFOs ====
//==== rev 1.0                                                                     ====
`default_nettype none

module cr_osf_dbg_step_sched
   import cr_osfPKG::*;
#(
   parameter int CNT_W    = OSF_STEP_CNT_W,
   parameter int STEP_GAP = OSF_STEP_GAP,
   parameter int TMO_W    = OSF_STEP_TMO_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step_cmd_valid,
   output logic             step_cmd_ready,
   input  logic             step_cmd_target,
   input  logic [CNT_W-1:0] step_cmd_count,
   input  logic             step_abort,
   input  logic             data_fifo_empty,
   input  logic             pdt_fifo_empty,
   input  logic             ob_data_fifo_afull,
   input  logic             ob_pdt_fifo_afull,
   output logic             data_fifo_single_step_rd,
   output logic             pdt_fifo_single_step_rd,
   output logic             step_busy,
   output logic             step_done,
   output logic             step_err,
   output logic             step_aborted,
   output logic [CNT_W-1:0] step_remaining,
   output logic [CNT_W-1:0] step_issued
);
   step_state_e state;
   step_tgt_e   target;

   logic accept;
   logic eligible;
   logic do_issue;
   logic do_stall;
   logic gap_done;
   logic timeout;

   assign accept   = (state == ST_IDLE) && step_cmd_valid;
   assign eligible = (target == STEP_TGT_DATA) ? (!data_fifo_empty && !ob_data_fifo_afull)
                                               : (!pdt_fifo_empty  && !ob_pdt_fifo_afull);
   assign do_issue = (state == ST_ISSUE) && !step_abort && eligible;
   assign do_stall = (state == ST_ISSUE) && !step_abort && !eligible;

   cr_osf_step_pacer #(
      .STEP_GAP (STEP_GAP),
      .TMO_W    (TMO_W)
   ) u_pacer (
      .clk       (clk),
      .rst_n     (rst_n),
      .gap_load  (do_issue),
      .gap_en    (state == ST_GAP),
      .stall_clr (accept || do_issue),
      .stall_inc (do_stall),
      .gap_done  (gap_done),
      .timeout   (timeout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state                    <= ST_IDLE;
         target                   <= STEP_TGT_DATA;
         step_cmd_ready           <= 1'b1;
         step_busy                <= 1'b0;
         step_done                <= 1'b0;
         step_err                 <= 1'b0;
         step_aborted             <= 1'b0;
         step_remaining           <= '0;
         step_issued              <= '0;
         data_fifo_single_step_rd <= 1'b0;
         pdt_fifo_single_step_rd  <= 1'b0;
      end else begin
         data_fifo_single_step_rd <= 1'b0;
         pdt_fifo_single_step_rd  <= 1'b0;
         step_done                <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (step_cmd_valid) begin
                  target         <= step_tgt_e'(step_cmd_target);
                  step_remaining <= step_cmd_count;
                  step_issued    <= '0;
                  step_err       <= 1'b0;
                  step_aborted   <= 1'b0;
                  step_cmd_ready <= 1'b0;
                  step_busy      <= 1'b1;
                  if (step_cmd_count == '0) begin
                     state     <= ST_DONE;
                     step_done <= 1'b1;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE: begin
               if (step_abort) begin
                  state        <= ST_DONE;
                  step_aborted <= 1'b1;
                  step_done    <= 1'b1;
               end else if (eligible) begin
                  data_fifo_single_step_rd <= (target == STEP_TGT_DATA);
                  pdt_fifo_single_step_rd  <= (target == STEP_TGT_PDT);
                  step_remaining           <= step_remaining - 1'b1;
                  step_issued              <= step_issued + 1'b1;
                  if (step_remaining == CNT_W'(1)) begin
                     state     <= ST_DONE;
                     step_done <= 1'b1;
                  end else begin
                     state <= ST_GAP;
                  end
               end else if (timeout) begin
                  state     <= ST_DONE;
                  step_err  <= 1'b1;
                  step_done <= 1'b1;
               end
            end

            ST_GAP: begin
               if (step_abort) begin
                  state        <= ST_DONE;
                  step_aborted <= 1'b1;
                  step_done    <= 1'b1;
               end else if (gap_done) begin
                  state <= ST_ISSUE;
               end
            end

            ST_DONE: begin
               state          <= ST_IDLE;
               step_cmd_ready <= 1'b1;
               step_busy      <= 1'b0;
            end

            default: begin
               state          <= ST_IDLE;
               step_cmd_ready <= 1'b1;
               step_busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_cr_osf_dbg_step_sched.sv
//==== tb_cr_osf_dbg_step_sched : scoreboard bench for the debug step scheduler ====
//==== rev 1.0                                                                  ====
`default_nettype none

module tb_cr_osf_dbg_step_sched;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst_n;
   logic             step_cmd_valid;
   logic             step_cmd_ready;
   logic             step_cmd_target;
   logic [CNT_W-1:0] step_cmd_count;
   logic             step_abort;
   logic             data_fifo_empty;
   logic             pdt_fifo_empty;
   logic             ob_data_fifo_afull;
   logic             ob_pdt_fifo_afull;
   logic             data_fifo_single_step_rd;
   logic             pdt_fifo_single_step_rd;
   logic             step_busy;
   logic             step_done;
   logic             step_err;
   logic             step_aborted;
   logic [CNT_W-1:0] step_remaining;
   logic [CNT_W-1:0] step_issued;

   cr_osf_dbg_step_sched #(
      .CNT_W    (CNT_W),
      .STEP_GAP (2),
      .TMO_W    (4)
   ) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .step_cmd_valid           (step_cmd_valid),
      .step_cmd_ready           (step_cmd_ready),
      .step_cmd_target          (step_cmd_target),
      .step_cmd_count           (step_cmd_count),
      .step_abort               (step_abort),
      .data_fifo_empty          (data_fifo_empty),
      .pdt_fifo_empty           (pdt_fifo_empty),
      .ob_data_fifo_afull       (ob_data_fifo_afull),
      .ob_pdt_fifo_afull        (ob_pdt_fifo_afull),
      .data_fifo_single_step_rd (data_fifo_single_step_rd),
      .pdt_fifo_single_step_rd  (pdt_fifo_single_step_rd),
      .step_busy                (step_busy),
      .step_done                (step_done),
      .step_err                 (step_err),
      .step_aborted             (step_aborted),
      .step_remaining           (step_remaining),
      .step_issued              (step_issued)
   );

   typedef struct {
      int   cyc;
      logic dpulse;
      logic ppulse;
      logic done;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic d, input logic p, input logic dn);
      exp_t e;
      e.cyc = c; e.dpulse = d; e.ppulse = p; e.done = dn;
      sb.push_back(e);
   endtask

   // Any observed pulse or done must match the next scoreboard entry, cycle included
   always @(negedge clk) begin
      if (data_fifo_single_step_rd || pdt_fifo_single_step_rd || step_done) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_event", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_cycle", cyc, e.cyc);
            chk("sb_data_pulse", {31'd0, data_fifo_single_step_rd}, {31'd0, e.dpulse});
            chk("sb_pdt_pulse", {31'd0, pdt_fifo_single_step_rd}, {31'd0, e.ppulse});
            chk("sb_done", {31'd0, step_done}, {31'd0, e.done});
         end
      end
   end

   // Drives a command for one cycle starting now (caller is #1 after an edge)
   task automatic send(input logic tgt, input int cnt, output int t0);
      chk("cmd_ready", {31'd0, step_cmd_ready}, 32'd1);
      step_cmd_valid  = 1'b1;
      step_cmd_target = tgt;
      step_cmd_count  = CNT_W'(cnt);
      t0 = cyc;
      @(posedge clk); #1;
      step_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (step_busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", {31'd0, step_busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst_n = 1'b0; step_cmd_valid = 1'b0; step_cmd_target = 1'b0; step_cmd_count = '0;
      step_abort = 1'b0; data_fifo_empty = 1'b0; pdt_fifo_empty = 1'b0;
      ob_data_fifo_afull = 1'b0; ob_pdt_fifo_afull = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_ready", {31'd0, step_cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, step_busy}, 32'd0);
      chk("rst_remaining", {16'd0, step_remaining}, 32'd0);
      chk("rst_issued", {16'd0, step_issued}, 32'd0);
      chk("rst_err_abort", {30'd0, step_err, step_aborted}, 32'd0);
      @(posedge clk); #1;

      // data target, 3 steps, continuously eligible
      send(1'b0, 3, t0);
      push(t0 + 2, 1'b1, 1'b0, 1'b0);
      push(t0 + 5, 1'b1, 1'b0, 1'b0);
      push(t0 + 8, 1'b1, 1'b0, 1'b1);
      chk("t1_busy", {31'd0, step_busy}, 32'd1);
      chk("t1_ready_low", {31'd0, step_cmd_ready}, 32'd0);
      wait_idle();
      chk("t1_issued", {16'd0, step_issued}, 32'd3);
      chk("t1_remaining", {16'd0, step_remaining}, 32'd0);
      chk("t1_err", {31'd0, step_err}, 32'd0);

      // PDT target, 2 steps, FIFO empty for the first 10 ISSUE cycles
      data_fifo_empty = 1'b1;
      pdt_fifo_empty  = 1'b1;
      send(1'b1, 2, t0);
      repeat (10) @(posedge clk);
      #1 pdt_fifo_empty = 1'b0;
      push(t0 + 12, 1'b0, 1'b1, 1'b0);
      push(t0 + 15, 1'b0, 1'b1, 1'b1);
      wait_idle();
      chk("t2_err", {31'd0, step_err}, 32'd0);
      chk("t2_issued", {16'd0, step_issued}, 32'd2);
      data_fifo_empty = 1'b0;

      // zero-count command
      send(1'b0, 0, t0);
      push(t0 + 1, 1'b0, 1'b0, 1'b1);
      wait_idle();
      chk("t3_remaining", {16'd0, step_remaining}, 32'd0);
      chk("t3_issued", {16'd0, step_issued}, 32'd0);

      // abort coincident with third eligible ISSUE cycle
      send(1'b0, 5, t0);
      push(t0 + 2, 1'b1, 1'b0, 1'b0);
      push(t0 + 5, 1'b1, 1'b0, 1'b0);
      push(t0 + 8, 1'b0, 1'b0, 1'b1);
      repeat (6) @(posedge clk);
      #1 step_abort = 1'b1;
      @(posedge clk);
      #1 step_abort = 1'b0;
      wait_idle();
      chk("t4_issued", {16'd0, step_issued}, 32'd2);
      chk("t4_remaining", {16'd0, step_remaining}, 32'd3);
      chk("t4_aborted", {31'd0, step_aborted}, 32'd1);

      // stall timeout after 15 ineligible cycles
      data_fifo_empty = 1'b1;
      send(1'b0, 1, t0);
      push(t0 + 16, 1'b0, 1'b0, 1'b1);
      wait_idle();
      chk("t5_err", {31'd0, step_err}, 32'd1);
      chk("t5_aborted_cleared", {31'd0, step_aborted}, 32'd0);
      chk("t5_remaining", {16'd0, step_remaining}, 32'd1);
      data_fifo_empty = 1'b0;
      send(1'b0, 1, t0);
      push(t0 + 2, 1'b1, 1'b0, 1'b1);
      chk("t5_err_cleared", {31'd0, step_err}, 32'd0);
      wait_idle();

      // reset during GAP, then immediate new command
      send(1'b0, 4, t0);
      push(t0 + 2, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("t6_rst_ready", {31'd0, step_cmd_ready}, 32'd1);
      chk("t6_rst_busy", {31'd0, step_busy}, 32'd0);
      chk("t6_rst_pulses", {30'd0, data_fifo_single_step_rd, pdt_fifo_single_step_rd}, 32'd0);
      chk("t6_rst_counts", {step_remaining, step_issued}, 32'd0);
      send(1'b0, 1, t0);
      push(t0 + 2, 1'b1, 1'b0, 1'b1);
      chk("t6_accepted", {31'd0, step_busy}, 32'd1);
      wait_idle();
      chk("t6_issued", {16'd0, step_issued}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
